// File: rtl/idli_salu_m.sv
// Multi-slice serial ALU: one SLICE_W slice per accepted beat, LSB first, over DATA_W/SLICE_W beats.
// Result slice is combinational; Z/N/C/V flags and compare result are registered at the end of the op.
module idli_salu_m #(
  parameter int SLICE_W = 4,
  parameter int DATA_W  = 16
) (
  input  logic               i_salu_gck,
  input  logic               i_salu_rst,
  input  logic               i_salu_start,
  input  logic               i_salu_vld,
  input  logic [2:0]         i_salu_op,
  input  logic [SLICE_W-1:0] i_salu_lhs,
  input  logic [SLICE_W-1:0] i_salu_rhs,
  output logic [SLICE_W-1:0] o_salu_out,
  output logic               o_salu_wen,
  output logic               o_salu_busy,
  output logic               o_salu_done,
  output logic [3:0]         o_salu_flags,
  output logic               o_salu_cond,
  output logic               o_salu_flags_vld
);

  localparam int NUM_BEATS = DATA_W / SLICE_W;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ANDN, OP_CMP_EQ, OP_CMP_LTU
  } op_e;

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  op_e              op_q, op_d;
  logic             zacc_q, zacc_d;
  logic [3:0]       flags_q, flags_d;
  logic             cond_q, cond_d;
  logic             flags_vld_q, flags_vld_d;

  logic             accept, last, is_sub, is_cmp, is_arith, cin, cout, c_msb, zacc_nxt;
  op_e              op_eff;
  logic [SLICE_W-1:0] rhs_eff, res;
  logic [SLICE_W:0]   sum;

  always_comb begin
    accept   = busy_q ? i_salu_vld : i_salu_start;
    op_eff   = busy_q ? op_q : op_e'(i_salu_op);
    is_cmp   = (op_eff == OP_CMP_EQ) || (op_eff == OP_CMP_LTU);
    is_sub   = (op_eff == OP_SUB) || is_cmp;
    is_arith = (op_eff == OP_ADD) || is_sub;
    rhs_eff  = is_sub ? ~i_salu_rhs : i_salu_rhs;
    // start beat seeds the chain: 0 for add, 1 for two's-complement subtract
    cin      = busy_q ? carry_q : is_sub;
    sum      = {1'b0, i_salu_lhs} + {1'b0, rhs_eff} + {{SLICE_W{1'b0}}, cin};
    cout     = sum[SLICE_W];
    // carry into the MSB recovered from the MSB sum bit
    c_msb    = i_salu_lhs[SLICE_W-1] ^ rhs_eff[SLICE_W-1] ^ sum[SLICE_W-1];
    res      = sum[SLICE_W-1:0];
    case (op_eff)
      OP_AND:  res = i_salu_lhs & i_salu_rhs;
      OP_OR:   res = i_salu_lhs | i_salu_rhs;
      OP_XOR:  res = i_salu_lhs ^ i_salu_rhs;
      OP_ANDN: res = i_salu_lhs & ~i_salu_rhs;
      default: res = sum[SLICE_W-1:0];
    endcase
    last     = (NUM_BEATS == 1) || (busy_q && (cnt_q == CNT_W'(NUM_BEATS - 1)));
    zacc_nxt = (busy_q ? zacc_q : 1'b1) & (res == '0);
  end

  always_comb begin
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    op_d        = op_q;
    zacc_d      = zacc_q;
    flags_d     = flags_q;
    cond_d      = cond_q;
    flags_vld_d = flags_vld_q;
    if (accept) begin
      if (is_arith) carry_d = cout;
      zacc_d = zacc_nxt;
      if (!busy_q) begin
        op_d        = op_e'(i_salu_op);
        flags_vld_d = 1'b0;
      end
      if (last) begin
        busy_d      = 1'b0;
        cnt_d       = '0;
        flags_d     = {zacc_nxt, res[SLICE_W-1], is_arith & cout, is_arith & (c_msb ^ cout)};
        cond_d      = (op_eff == OP_CMP_EQ)  ? zacc_nxt :
                      (op_eff == OP_CMP_LTU) ? ~cout    : 1'b0;
        flags_vld_d = 1'b1;
      end else begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_salu_gck or posedge i_salu_rst) begin
    if (i_salu_rst) begin
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      op_q        <= OP_ADD;
      zacc_q      <= 1'b0;
      flags_q     <= 4'b0;
      cond_q      <= 1'b0;
      flags_vld_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      op_q        <= op_d;
      zacc_q      <= zacc_d;
      flags_q     <= flags_d;
      cond_q      <= cond_d;
      flags_vld_q <= flags_vld_d;
    end
  end

  assign o_salu_out       = res;
  assign o_salu_wen       = accept && !is_cmp;
  assign o_salu_busy      = busy_q;
  assign o_salu_done      = accept && last;
  assign o_salu_flags     = flags_q;
  assign o_salu_cond      = cond_q;
  assign o_salu_flags_vld = flags_vld_q;

endmodule

// File: tb/tb_idli_salu_m.sv
// Directed bench for idli_salu_m: a 16b/4b-slice instance and a single-beat 4b/4b instance.
module tb_idli_salu_m;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_start = 0, a_vld = 0;
  logic [2:0] a_op = 0;
  logic [3:0] a_lhs = 0, a_rhs = 0;
  logic [3:0] a_out, a_flags;
  logic       a_wen, a_busy, a_done, a_cond, a_fvld;

  logic       b_start = 0, b_vld = 0;
  logic [2:0] b_op = 0;
  logic [3:0] b_lhs = 0, b_rhs = 0;
  logic [3:0] b_out, b_flags;
  logic       b_wen, b_busy, b_done, b_cond, b_fvld;

  idli_salu_m #(.SLICE_W(4), .DATA_W(16)) u_a (
    .i_salu_gck(clk), .i_salu_rst(rst), .i_salu_start(a_start), .i_salu_vld(a_vld),
    .i_salu_op(a_op), .i_salu_lhs(a_lhs), .i_salu_rhs(a_rhs), .o_salu_out(a_out),
    .o_salu_wen(a_wen), .o_salu_busy(a_busy), .o_salu_done(a_done),
    .o_salu_flags(a_flags), .o_salu_cond(a_cond), .o_salu_flags_vld(a_fvld));

  idli_salu_m #(.SLICE_W(4), .DATA_W(4)) u_b (
    .i_salu_gck(clk), .i_salu_rst(rst), .i_salu_start(b_start), .i_salu_vld(b_vld),
    .i_salu_op(b_op), .i_salu_lhs(b_lhs), .i_salu_rhs(b_rhs), .o_salu_out(b_out),
    .o_salu_wen(b_wen), .o_salu_busy(b_busy), .o_salu_done(b_done),
    .o_salu_flags(b_flags), .o_salu_cond(b_cond), .o_salu_flags_vld(b_fvld));

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, LTU = 3'd7;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one beat on instance A at the falling edge and check its combinational outputs.
  task automatic a_beat(input logic st, input logic v, input logic [2:0] op,
                        input logic [3:0] l, input logic [3:0] r,
                        input logic [3:0] eo, input logic ew, input logic ed, input string tag);
    @(negedge clk);
    a_start = st; a_vld = v; a_op = op; a_lhs = l; a_rhs = r;
    #1;
    chk({tag, "_out"},  a_out,  eo);
    chk({tag, "_wen"},  a_wen,  ew);
    chk({tag, "_done"}, a_done, ed);
  endtask

  // Let the current beat be taken, then drop the handshake.
  task automatic a_end();
    @(posedge clk); #1;
    a_start = 0; a_vld = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy",  a_busy, 0);
    chk("rst_wen",   a_wen,  0);
    chk("rst_done",  a_done, 0);
    chk("rst_flags", a_flags, 0);
    chk("rst_cond",  a_cond, 0);
    chk("rst_fvld",  a_fvld, 0);
    rst = 0;

    // ADD 0x00FF + 0x0001
    a_beat(1, 0, ADD, 4'hF, 4'h1, 4'h0, 1, 0, "add_b0");
    a_beat(0, 1, ADD, 4'hF, 4'h0, 4'h0, 1, 0, "add_b1");
    chk("add_busy", a_busy, 1);
    a_beat(0, 1, ADD, 4'h0, 4'h0, 4'h1, 1, 0, "add_b2");
    a_beat(0, 1, ADD, 4'h0, 4'h0, 4'h0, 1, 1, "add_b3");
    a_end();
    chk("add_flags", a_flags, 4'b0000);
    chk("add_fvld",  a_fvld, 1);
    chk("add_idle",  a_busy, 0);

    // SUB 0x0005 - 0x0005
    a_beat(1, 0, SUB, 4'h5, 4'h5, 4'h0, 1, 0, "sub_b0");
    a_beat(0, 1, SUB, 4'h0, 4'h0, 4'h0, 1, 0, "sub_b1");
    a_beat(0, 1, SUB, 4'h0, 4'h0, 4'h0, 1, 0, "sub_b2");
    a_beat(0, 1, SUB, 4'h0, 4'h0, 4'h0, 1, 1, "sub_b3");
    a_end();
    chk("sub_flags", a_flags, 4'b1010);
    chk("sub_cond",  a_cond, 0);

    // CMP_LTU 0x0003 < 0x0010
    a_beat(1, 0, LTU, 4'h3, 4'h0, 4'h3, 0, 0, "ltu1_b0");
    a_beat(0, 1, LTU, 4'h0, 4'h1, 4'hF, 0, 0, "ltu1_b1");
    a_beat(0, 1, LTU, 4'h0, 4'h0, 4'hF, 0, 0, "ltu1_b2");
    a_beat(0, 1, LTU, 4'h0, 4'h0, 4'hF, 0, 1, "ltu1_b3");
    a_end();
    chk("ltu1_cond",  a_cond, 1);
    chk("ltu1_flags", a_flags, 4'b0100);

    // CMP_LTU 0x0010 < 0x0003 is false
    a_beat(1, 0, LTU, 4'h0, 4'h3, 4'hD, 0, 0, "ltu2_b0");
    @(posedge clk); #1;
    chk("ltu2_fvld_clr", a_fvld, 0);
    a_beat(0, 1, LTU, 4'h1, 4'h0, 4'h0, 0, 0, "ltu2_b1");
    a_beat(0, 1, LTU, 4'h0, 4'h0, 4'h0, 0, 0, "ltu2_b2");
    a_beat(0, 1, LTU, 4'h0, 4'h0, 4'h0, 0, 1, "ltu2_b3");
    a_end();
    chk("ltu2_cond",  a_cond, 0);
    chk("ltu2_flags", a_flags, 4'b0010);
    chk("ltu2_fvld",  a_fvld, 1);

    // ADD 0x7FFF + 0x0001 with a two-cycle stall after beat 1; a SUB start inside the stall is ignored
    a_beat(1, 0, ADD, 4'hF, 4'h1, 4'h0, 1, 0, "ovf_b0");
    a_beat(0, 1, ADD, 4'hF, 4'h0, 4'h0, 1, 0, "ovf_b1");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a_start = (i == 0); a_vld = 0; a_op = SUB; a_lhs = 4'h3; a_rhs = 4'h9;
      #1;
      chk("stall_wen",  a_wen,  0);
      chk("stall_done", a_done, 0);
      chk("stall_busy", a_busy, 1);
    end
    a_beat(0, 1, ADD, 4'hF, 4'h0, 4'h0, 1, 0, "ovf_b2");
    a_beat(0, 1, ADD, 4'h7, 4'h0, 4'h8, 1, 1, "ovf_b3");
    a_end();
    chk("ovf_flags", a_flags, 4'b0101);

    // Reset after beat 2 of an ADD, then a clean ADD 0x1234 + 0x1111
    a_beat(1, 0, ADD, 4'h9, 4'h9, 4'h2, 1, 0, "rst_b0");
    a_beat(0, 1, ADD, 4'h9, 4'h9, 4'h3, 1, 0, "rst_b1");
    a_beat(0, 1, ADD, 4'h9, 4'h9, 4'h3, 1, 0, "rst_b2");
    a_end();
    rst = 1;
    #1;
    chk("midrst_busy",  a_busy, 0);
    chk("midrst_flags", a_flags, 0);
    chk("midrst_fvld",  a_fvld, 0);
    @(negedge clk);
    rst = 0;
    a_beat(1, 0, ADD, 4'h4, 4'h1, 4'h5, 1, 0, "post_b0");
    a_beat(0, 1, ADD, 4'h3, 4'h1, 4'h4, 1, 0, "post_b1");
    a_beat(0, 1, ADD, 4'h2, 4'h1, 4'h3, 1, 0, "post_b2");
    a_beat(0, 1, ADD, 4'h1, 4'h1, 4'h2, 1, 1, "post_b3");
    a_end();
    chk("post_flags", a_flags, 4'b0000);

    // Single-beat instance: ADD 0xF + 0x1, then AND back-to-back, then ADD 1+1 with fresh carry
    @(negedge clk);
    b_start = 1; b_op = ADD; b_lhs = 4'hF; b_rhs = 4'h1;
    #1;
    chk("b_add_out",  b_out,  4'h0);
    chk("b_add_done", b_done, 1);
    chk("b_add_wen",  b_wen,  1);
    chk("b_add_busy", b_busy, 0);
    @(posedge clk); #1;
    chk("b_add_flags", b_flags, 4'b1010);
    chk("b_add_fvld",  b_fvld, 1);
    chk("b_add_busy2", b_busy, 0);
    b_op = AND; b_lhs = 4'hC; b_rhs = 4'hA;
    #1;
    chk("b_and_out",  b_out,  4'h8);
    chk("b_and_done", b_done, 1);
    @(posedge clk); #1;
    chk("b_and_flags", b_flags, 4'b0100);
    b_op = ADD; b_lhs = 4'h1; b_rhs = 4'h1;
    #1;
    chk("b_add2_out", b_out, 4'h2);
    @(posedge clk); #1;
    b_start = 0;
    chk("b_add2_flags", b_flags, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/idli_salu_m.md
Name: idli_salu_m

Overview:
Parametrised multi-slice serial ALU; successor to the fixed 4b serial ALU. Consumes one SLICE_W-bit slice of each operand per cycle, LSB slice first, over DATA_W/SLICE_W beats. Tracks its own beat counter, carry chain and condition flags, and handshakes with the sequencer via start/valid/done. Adds subtract, AND-NOT, compare modes and registered Z/N/C/V flags, none of which the predecessor has.

Parameters:
SLICE_W, 4, bits processed per beat; must be >= 1.
DATA_W, 16, full operand width; must be a multiple of SLICE_W.
NUM_BEATS (localparam), DATA_W/SLICE_W, beats per operation; counter width is clog2(NUM_BEATS), minimum 1.

Ports:
i_salu_gck  in  1  clock.
i_salu_rst  in  1  reset, asynchronous, active-high.
i_salu_start  in  1  begin a new operation; implies slice 0 is valid this cycle.
i_salu_vld  in  1  slice valid for beats 1..NUM_BEATS-1; low = stall.
i_salu_op  in  3  opcode, sampled only on an accepted start: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ANDN (lhs & ~rhs), 6 CMP_EQ, 7 CMP_LTU.
i_salu_lhs  in  SLICE_W  lhs slice.
i_salu_rhs  in  SLICE_W  rhs slice.
o_salu_out  out  SLICE_W  result slice; combinational, same cycle as the input slice.
o_salu_wen  out  1  out is a writeback slice: beat accepted and op not CMP_*.
o_salu_busy  out  1  operation in progress, beats 1..NUM_BEATS-1 outstanding.
o_salu_done  out  1  combinational; high in the cycle the last slice is accepted.
o_salu_flags  out  4  registered {Z,N,C,V}.
o_salu_cond  out  1  registered compare result.
o_salu_flags_vld  out  1  flags/cond valid.

Behaviour:
- Reset (async assert): busy=0, beat counter=0, carry=0, latched op=ADD, flags=0, cond=0, flags_vld=0. All combinational outputs follow from this state: wen=0, done=0.
- Beat acceptance:
  - Idle: a beat is accepted when start=1.
  - Busy: a beat is accepted when vld=1. start is ignored while busy; the counter and op are unaffected.
- Opcode selection: the effective op is i_salu_op on the start beat and the latched op on later beats.
- Stall: when busy and vld=0, all state holds, wen=0, done=0. Stall length is unbounded.
- Arithmetic per beat:
  - ADD: {cout,out} = lhs + rhs + cin.
  - SUB/CMP_*: {cout,out} = lhs + ~rhs + cin.
  - cin = carry_q on later beats. On the start beat, cin = 0 for ADD and 1 for SUB/CMP.
  - carry_q <= cout on every accepted beat.
  - Logic ops leave the carry register unchanged and report C=0, V=0.
- Zero tracking: zacc is a running AND of (out==0) over all accepted beats of the op, initialised on the start beat.
- Beat counter: increments per accepted beat. The last beat is counter==NUM_BEATS-1, or the start beat itself when NUM_BEATS==1. On the last beat the counter returns to 0 and busy clears.
- Flags, captured on the clock edge ending the last beat:
  - Z = zacc including the last slice.
  - N = out[SLICE_W-1] of the last slice.
  - C = final cout.
  - V = carry into the MSB XOR cout, from the last slice (arith ops only).
- cond: CMP_EQ -> Z; CMP_LTU -> ~C (borrow); other ops -> 0.
- flags_vld: set with the flag capture; cleared on the next accepted start; otherwise holds.
- A new start is allowed in the cycle after done. Back-to-back ops have no dead cycle.
- Reset mid-operation: returns to idle immediately. Partial result is discarded; flags and flags_vld are cleared.

Test Plan:
- ADD 0x00FF+0x0001, 4 beats no stall -> out slices 0,0,1,0; wen=1 each beat; done on beat 3; next cycle flags Z=0 N=0 C=0 V=0, flags_vld=1.
- SUB 0x0005-0x0005 -> slices 0,0,0,0; flags Z=1 N=0 C=1 V=0.
- CMP_LTU lhs=0x0003 rhs=0x0010 -> wen=0 all beats; cond=1, C=0. Repeat with lhs=0x0010 rhs=0x0003 -> cond=0.
- ADD 0x7FFF+0x0001 with vld low for 2 cycles after beat 1 -> no wen/done during the stall; result 0x8000; flags N=1 V=1 C=0 Z=0. A start pulse during the stall is ignored.
- Reset mid-op: start ADD, reset after beat 2 -> busy=0, flags=0, flags_vld=0. A fresh ADD 0x1234+0x1111 then gives slices 5,4,3,2.
- SLICE_W=DATA_W=4: ADD 0xF+0x1 on start -> out=0x0 with done the same cycle and busy never set; then Z=1 C=1 V=0. Also run an AND op to confirm C=0, V=0.
